// File: rtl/st7789_spi_tx.sv
// st7789_spi_tx
//
// Serializes the ST7789 manager's command/data byte stream onto the 4-wire SPI
// pins of the panel (SPI mode 0, MSB first). One AXI-Stream beat carries one
// byte; TUSER drives D/C, TLAST closes the chip-select transaction.
//
// Parameters:
//   CLK_DIV  SCL half-period in CLK cycles (1..255)
//   CS_GAP   CLK cycles CS_N is held high after a TLAST byte (1..255)
//
// Ports:
//   CLK, RESET         system clock, synchronous active-high reset
//   S_AXIS_TDATA       byte to send
//   S_AXIS_TKEEP       0 = consume the beat without shifting it out
//   S_AXIS_TUSER       0 = command (DC low), 1 = parameter/pixel data (DC high)
//   S_AXIS_TVALID      beat valid
//   S_AXIS_TLAST       last byte of the CS transaction
//   S_AXIS_TREADY      high in IDLE and WAIT only
//   LCD_SCL/SDA/DC     SPI clock (idle low), MOSI, data/command select
//   LCD_CS_N           chip select, active low
//   BUSY               high whenever the FSM is not idle
module st7789_spi_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] S_AXIS_TDATA,
  input  logic       S_AXIS_TKEEP,
  input  logic       S_AXIS_TUSER,
  input  logic       S_AXIS_TVALID,
  input  logic       S_AXIS_TLAST,
  output logic       S_AXIS_TREADY,
  output logic       LCD_SCL,
  output logic       LCD_SDA,
  output logic       LCD_DC,
  output logic       LCD_CS_N,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StWait,
    StGap
  } state_t;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLast = 8'(CS_GAP - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_div_cnt, w_div_cnt_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_gap_cnt, w_gap_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_last, w_last_nxt;
  logic       r_scl, w_scl_nxt;
  logic       r_dc, w_dc_nxt;
  logic       r_cs_n, w_cs_n_nxt;

  logic       w_ready_state;
  logic       w_hs;

  // Ready is decoded from the registered state only; RESET just masks it.
  assign w_ready_state = (r_state == StIdle) || (r_state == StWait);
  assign w_hs          = w_ready_state && S_AXIS_TVALID;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= StIdle;
      r_div_cnt <= 8'd0;
      r_bit_cnt <= 3'd0;
      r_gap_cnt <= 8'd0;
      r_shift   <= 8'd0;
      r_last    <= 1'b0;
      r_scl     <= 1'b0;
      r_dc      <= 1'b0;
      r_cs_n    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_last    <= w_last_nxt;
      r_scl     <= w_scl_nxt;
      r_dc      <= w_dc_nxt;
      r_cs_n    <= w_cs_n_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_div_cnt_nxt = r_div_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_shift_nxt   = r_shift;
    w_last_nxt    = r_last;
    w_scl_nxt     = r_scl;
    w_dc_nxt      = r_dc;
    w_cs_n_nxt    = r_cs_n;

    case (r_state)
      StIdle, StWait: begin
        if (w_hs) begin
          if (S_AXIS_TKEEP) begin
            w_shift_nxt   = S_AXIS_TDATA;
            w_dc_nxt      = S_AXIS_TUSER;
            w_last_nxt    = S_AXIS_TLAST;
            w_cs_n_nxt    = 1'b0;
            w_bit_cnt_nxt = 3'd7;
            w_div_cnt_nxt = 8'd0;
            w_state_nxt   = StSetup;
          end else if (S_AXIS_TLAST) begin
            // A dropped TLAST beat still closes the transaction.
            w_cs_n_nxt    = 1'b1;
            w_gap_cnt_nxt = 8'd0;
            w_state_nxt   = StGap;
          end
        end
      end

      StSetup: begin
        if (r_div_cnt == DivLast) begin
          w_div_cnt_nxt = 8'd0;
          w_scl_nxt     = 1'b1;
          w_state_nxt   = StHigh;
        end else begin
          w_div_cnt_nxt = r_div_cnt + 8'd1;
        end
      end

      StHigh: begin
        if (r_div_cnt == DivLast) begin
          w_div_cnt_nxt = 8'd0;
          w_scl_nxt     = 1'b0;
          if (r_bit_cnt != 3'd0) begin
            w_shift_nxt   = {r_shift[6:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt - 3'd1;
            w_state_nxt   = StSetup;
          end else if (r_last) begin
            // CS_N rises on the same edge as the final SCL fall.
            w_cs_n_nxt    = 1'b1;
            w_gap_cnt_nxt = 8'd0;
            w_state_nxt   = StGap;
          end else begin
            // SDA keeps bit 0 while waiting for the next byte.
            w_state_nxt = StWait;
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + 8'd1;
        end
      end

      StGap: begin
        if (r_gap_cnt == GapLast) begin
          w_gap_cnt_nxt = 8'd0;
          w_state_nxt   = StIdle;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 8'd1;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign S_AXIS_TREADY = w_ready_state && !RESET;
  assign LCD_SCL       = r_scl;
  assign LCD_SDA       = r_shift[7];
  assign LCD_DC        = r_dc;
  assign LCD_CS_N      = r_cs_n;
  assign BUSY          = (r_state != StIdle);

endmodule

// File: tb/tb_st7789_spi_tx.sv
// tb_st7789_spi_tx
//
// Directed bench for st7789_spi_tx. Two instances share one stimulus bus:
// u_dut_div2 (CLK_DIV=2) and u_dut_div1 (CLK_DIV=1), both CS_GAP=4; 'sel'
// chooses which one receives TVALID and which one the pin monitor watches.
// The monitor decodes bytes at SCL rises, counts CS_N low cycles/windows and
// flags SDA/DC moving while SCL is high.
module tb_st7789_spi_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tdata;
  logic       tkeep, tuser, tvalid, tlast;
  logic       sel;

  logic a_tready, a_scl, a_sda, a_dc, a_cs_n, a_busy;
  logic b_tready, b_scl, b_sda, b_dc, b_cs_n, b_busy;
  logic a_tvalid, b_tvalid;
  logic tready, scl, sda, dc, cs_n, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign a_tvalid = tvalid & ~sel;
  assign b_tvalid = tvalid & sel;
  assign tready   = sel ? b_tready : a_tready;
  assign scl      = sel ? b_scl : a_scl;
  assign sda      = sel ? b_sda : a_sda;
  assign dc       = sel ? b_dc : a_dc;
  assign cs_n     = sel ? b_cs_n : a_cs_n;
  assign busy     = sel ? b_busy : a_busy;

  st7789_spi_tx #(.CLK_DIV(2), .CS_GAP(4)) u_dut_div2 (
    .CLK(clk), .RESET(rst), .S_AXIS_TDATA(tdata), .S_AXIS_TKEEP(tkeep),
    .S_AXIS_TUSER(tuser), .S_AXIS_TVALID(a_tvalid), .S_AXIS_TLAST(tlast),
    .S_AXIS_TREADY(a_tready), .LCD_SCL(a_scl), .LCD_SDA(a_sda), .LCD_DC(a_dc),
    .LCD_CS_N(a_cs_n), .BUSY(a_busy)
  );

  st7789_spi_tx #(.CLK_DIV(1), .CS_GAP(4)) u_dut_div1 (
    .CLK(clk), .RESET(rst), .S_AXIS_TDATA(tdata), .S_AXIS_TKEEP(tkeep),
    .S_AXIS_TUSER(tuser), .S_AXIS_TVALID(b_tvalid), .S_AXIS_TLAST(tlast),
    .S_AXIS_TREADY(b_tready), .LCD_SCL(b_scl), .LCD_SDA(b_sda), .LCD_DC(b_dc),
    .LCD_CS_N(b_cs_n), .BUSY(b_busy)
  );

  // Pin monitor
  int         rise_cnt, cs_low, cs_windows, nbits, viol, cyc, last_rise, first_gap;
  logic [7:0] acc;
  logic       prev_scl = 1'b0, prev_sda = 1'b0, prev_dc = 1'b0, prev_cs = 1'b1;
  logic [7:0] cap_bytes[$];
  logic       cap_dc[$];

  always @(negedge clk) begin
    if (scl && !prev_scl) begin
      rise_cnt++;
      if (rise_cnt == 2) first_gap = cyc - last_rise;
      last_rise = cyc;
      acc = {acc[6:0], sda};
      nbits++;
      if (nbits == 8) begin
        cap_bytes.push_back(acc);
        cap_dc.push_back(dc);
        nbits = 0;
      end
    end
    if (scl && (sda !== prev_sda || dc !== prev_dc)) viol++;
    if (!cs_n) cs_low++;
    if (!cs_n && prev_cs) cs_windows++;
    prev_scl = scl;
    prev_sda = sda;
    prev_dc  = dc;
    prev_cs  = cs_n;
    cyc++;
  end

  task automatic clear_mon();
    rise_cnt = 0; cs_low = 0; cs_windows = 0; nbits = 0; viol = 0;
    first_gap = 0; acc = 8'd0;
    cap_bytes.delete();
    cap_dc.delete();
  endtask

  // Presents one beat and returns just after the handshake edge, TVALID still high.
  task automatic send_beat(input logic [7:0] d, input logic u, input logic l, input logic k);
    int n = 0;
    tdata = d; tuser = u; tlast = l; tkeep = k; tvalid = 1'b1;
    while (tready !== 1'b1 && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL send_timeout tready=%b want 1", tready);
    end
    @(posedge clk); #1;
  endtask

  // Waits for CS_N to rise, then counts cycles until TREADY returns.
  task automatic wait_gap(output int g);
    int n = 0;
    g = 0;
    while (cs_n === 1'b0 && n < 5000) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL cs_release_timeout cs_n=%b want 1", cs_n);
    end
    while (tready !== 1'b1 && g < 100) begin
      @(negedge clk); #1; g++;
    end
  endtask

  logic [7:0] burst_d[5] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'hEF};
  logic       burst_u[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  // Sends the CASET burst; with stall set, TVALID drops for 20 cycles after byte 2.
  task automatic run_burst(input bit stall, output int g, output int wait_bad);
    int n;
    wait_bad = 0;
    for (int i = 0; i < 5; i++) begin
      send_beat(burst_d[i], burst_u[i], (i == 4), 1'b1);
      if (stall && i == 2) begin
        tvalid = 1'b0;
        n = 0;
        while (tready !== 1'b1 && n < 500) begin
          @(negedge clk); #1; n++;
        end
        for (int c = 0; c < 20; c++) begin
          if (!(tready === 1'b1 && cs_n === 1'b0 && scl === 1'b0 && busy === 1'b1)) wait_bad++;
          @(negedge clk); #1;
        end
      end
    end
    tvalid = 1'b0;
    wait_gap(g);
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", tready); end
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n got %b want 1", cs_n); end
    checks++; if (scl !== 1'b0 || sda !== 1'b0 || dc !== 1'b0) begin
      errors++; $display("FAIL rst_pins scl/sda/dc got %b%b%b want 000", scl, sda, dc);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    rst = 1'b0; #1;
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL rst_release_tready got %b want 1", tready); end
    @(negedge clk); #1;
    clear_mon();
  endtask

  task automatic test_single();
    int g;
    clear_mon();
    send_beat(8'h2C, 1'b0, 1'b1, 1'b1);
    tvalid = 1'b0;
    checks++; if (cs_n !== 1'b0 || sda !== 1'b0) begin
      errors++; $display("FAIL single_load cs_n/sda got %b/%b want 0/0", cs_n, sda);
    end
    wait_gap(g);
    checks++; if (cs_low != 32) begin errors++; $display("FAIL single_cs_low got %0d want 32", cs_low); end
    checks++; if (rise_cnt != 8) begin errors++; $display("FAIL single_rises got %0d want 8", rise_cnt); end
    checks++; if (cap_bytes.size() != 1 || cap_bytes[0] !== 8'h2C || cap_dc[0] !== 1'b0) begin
      errors++; $display("FAIL single_byte got n=%0d b=%h want n=1 b=2c dc=0", cap_bytes.size(), acc);
    end
    checks++; if (g != 4) begin errors++; $display("FAIL single_gap got %0d want 4", g); end
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", tready); end
    checks++; if (first_gap != 4) begin errors++; $display("FAIL single_scl_period got %0d want 4", first_gap); end
    checks++; if (viol != 0) begin errors++; $display("FAIL single_stable got %0d want 0", viol); end
  endtask

  task automatic check_burst(input int g, input int want_low);
    logic [7:0] b;
    logic       d;
    checks++; if (cs_windows != 1) begin errors++; $display("FAIL burst_windows got %0d want 1", cs_windows); end
    checks++; if (cs_low != want_low) begin errors++; $display("FAIL burst_cs_low got %0d want %0d", cs_low, want_low); end
    checks++; if (rise_cnt != 40) begin errors++; $display("FAIL burst_rises got %0d want 40", rise_cnt); end
    for (int i = 0; i < 5; i++) begin
      b = (i < cap_bytes.size()) ? cap_bytes[i] : 8'hxx;
      d = (i < cap_dc.size()) ? cap_dc[i] : 1'bx;
      checks++; if (b !== burst_d[i] || d !== burst_u[i]) begin
        errors++; $display("FAIL burst_byte%0d got %h/%b want %h/%b", i, b, d, burst_d[i], burst_u[i]);
      end
    end
    checks++; if (g != 4) begin errors++; $display("FAIL burst_gap got %0d want 4", g); end
    checks++; if (viol != 0) begin errors++; $display("FAIL burst_stable got %0d want 0", viol); end
  endtask

  task automatic test_back_to_back();
    int g, wb;
    clear_mon();
    run_burst(1'b0, g, wb);
    check_burst(g, 5 * 33 - 1);
  endtask

  task automatic test_stall();
    int g, wb;
    clear_mon();
    run_burst(1'b1, g, wb);
    checks++; if (wb != 0) begin errors++; $display("FAIL stall_wait_state got %0d bad cycles want 0", wb); end
    check_burst(g, 5 * 33 - 1 + 20);
  endtask

  task automatic test_tkeep();
    int g;
    clear_mon();
    send_beat(8'h55, 1'b1, 1'b0, 1'b0);
    tvalid = 1'b0;
    checks++; if (cs_n !== 1'b1 || busy !== 1'b0 || tready !== 1'b1) begin
      errors++; $display("FAIL tkeep_skip cs_n/busy/tready got %b%b%b want 101", cs_n, busy, tready);
    end
    send_beat(8'h01, 1'b0, 1'b1, 1'b1);
    tvalid = 1'b0;
    wait_gap(g);
    checks++; if (rise_cnt != 8) begin errors++; $display("FAIL tkeep_rises got %0d want 8", rise_cnt); end
    checks++; if (cap_bytes.size() != 1 || cap_bytes[0] !== 8'h01 || cap_dc[0] !== 1'b0) begin
      errors++; $display("FAIL tkeep_byte got n=%0d acc=%h want n=1 01 dc=0", cap_bytes.size(), acc);
    end
  endtask

  task automatic test_reset_mid_byte();
    int g, n;
    clear_mon();
    send_beat(8'hFF, 1'b0, 1'b1, 1'b1);
    tvalid = 1'b0;
    n = 0;
    while (rise_cnt < 3 && n < 500) begin
      @(negedge clk); #1; n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (cs_n !== 1'b1 || scl !== 1'b0 || busy !== 1'b0 || tready !== 1'b0) begin
      errors++; $display("FAIL midrst_pins cs_n/scl/busy/tready got %b%b%b%b want 1000",
                         cs_n, scl, busy, tready);
    end
    @(negedge clk); #1;
    rst = 1'b0; #1;
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", tready); end
    repeat (10) begin @(negedge clk); #1; end
    checks++; if (rise_cnt != 3) begin errors++; $display("FAIL midrst_no_trail got %0d want 3", rise_cnt); end
    clear_mon();
    send_beat(8'h11, 1'b0, 1'b1, 1'b1);
    tvalid = 1'b0;
    wait_gap(g);
    checks++; if (rise_cnt != 8 || cap_bytes.size() != 1 || cap_bytes[0] !== 8'h11) begin
      errors++; $display("FAIL midrst_next got rises=%0d n=%0d want 8 rises byte 11", rise_cnt,
                         cap_bytes.size());
    end
  endtask

  task automatic test_div1_pixels();
    logic [7:0] px[6] = '{8'hF8, 8'h00, 8'h1F, 8'hF8, 8'h00, 8'h1F};
    logic [7:0] b;
    int g;
    sel = 1'b1;
    rst = 1'b1;
    repeat (2) begin @(negedge clk); #1; end
    rst = 1'b0;
    repeat (2) begin @(negedge clk); #1; end
    clear_mon();
    for (int i = 0; i < 6; i++) send_beat(px[i], 1'b1, (i == 5), 1'b1);
    tvalid = 1'b0;
    wait_gap(g);
    checks++; if (cs_low != 6 * 17 - 1) begin errors++; $display("FAIL div1_cs_low got %0d want 101", cs_low); end
    checks++; if (rise_cnt != 48) begin errors++; $display("FAIL div1_rises got %0d want 48", rise_cnt); end
    checks++; if (first_gap != 2) begin errors++; $display("FAIL div1_scl_period got %0d want 2", first_gap); end
    for (int i = 0; i < 6; i++) begin
      b = (i < cap_bytes.size()) ? cap_bytes[i] : 8'hxx;
      checks++; if (b !== px[i] || (i < cap_dc.size() && cap_dc[i] !== 1'b1)) begin
        errors++; $display("FAIL div1_byte%0d got %h want %h dc=1", i, b, px[i]);
      end
    end
    checks++; if (g != 4) begin errors++; $display("FAIL div1_gap got %0d want 4", g); end
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; tvalid = 1'b0; tdata = 8'h00;
    tkeep = 1'b1; tuser = 1'b0; tlast = 1'b0;
    clear_mon();
    cyc = 0; last_rise = 0;
    repeat (3) @(posedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_tkeep();
    test_reset_mid_byte();
    test_div1_pixels();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
